// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// quotient to LO, remainder to HI, with MIPS truncate-toward-zero signing.
module mips_seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             dvd_sign, dsr_sign;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH+1:0] shifted, diff;
  logic             borrow;

  always_comb begin
    dvd_sign = is_signed & dividend[WIDTH-1];
    dsr_sign = is_signed & divisor[WIDTH-1];
    dvd_mag  = dvd_sign ? ('0 - dividend) : dividend;
    dsr_mag  = dsr_sign ? ('0 - divisor)  : divisor;

    // Top accumulator bit is always zero between steps; it only widens the trial subtract.
    shifted = {acc_q, dvd_q[WIDTH-1]};
    diff    = shifted - {2'b00, dsr_q};
    borrow  = diff[WIDTH+1];

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = CW'(WIDTH);
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = dvd_mag;
            dsr_d   = dsr_mag;
            qneg_d  = dvd_sign ^ dsr_sign;
            rneg_d  = dvd_sign;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = qneg_q ? ('0 - dvd_q) : dvd_q;
        rem_d   = rneg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/mips_seq_divider.md
Name: mips_seq_divider

Overview:
- Multi-cycle restoring divider for the MiniMIPS datapath, implementing DIV and DIVU.
- Produces quotient (to LO) and remainder (to HI).
- Retires one quotient bit per cycle using a single WIDTH+1-bit subtractor, the inverse operation of the adder chain built from full_adder cells.
- Sits beside the ALU; the control unit stalls on busy and writes HI/LO when done pulses.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse; results valid
quotient  output  WIDTH  LO result, held until next accepted start
remainder  output  WIDTH  HI result, held until next accepted start
div_by_zero  output  1  set with done when divisor was 0; held like results

Behaviour:
- One clock. Reset is synchronous and active-high; ports are named clock and reset.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE.
- States:
  - IDLE, RUN, FIX, DONE.
  - IDLE: start=1 at edge T latches the operands, clears the remainder accumulator, and loads the iteration counter with WIDTH.
    - divisor!=0 -> RUN.
    - divisor==0 -> DONE.
  - RUN: each cycle, shift {acc, dvd} left by 1 and trial-subtract the magnitude of the divisor from acc (WIDTH+1 bits).
    - Non-negative difference: acc=diff, quotient bit=1.
    - Otherwise: restore acc, quotient bit=0.
    - The counter decrements; after WIDTH iterations -> FIX.
  - FIX: apply sign correction, then register quotient and remainder -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- Latency with start accepted at edge T:
  - Normal case: busy=1 in cycles T+1..T+WIDTH+1; done=1 in cycle T+WIDTH+2; busy=0 in the done cycle.
  - Divide by zero: done=1 in cycle T+1; busy never asserts.
- Signed mode:
  - Operate on magnitudes.
  - Quotient negated iff the operand signs differ.
  - Remainder takes the sign of the dividend, so truncation is toward zero (MIPS semantics).
- Unsigned mode: no correction.
- Overflow: signed -2^(WIDTH-1) / -1 gives quotient=0x80000000 and remainder=0 (WIDTH=32), as produced by the magnitude algorithm plus negation. No flag is raised.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1. Signedness is ignored.
- start while busy or in DONE: ignored. Latched operands and in-flight state are unaffected.
- Input changes after acceptance have no effect.
- quotient, remainder and div_by_zero change only at the FIX->DONE edge (or the IDLE->DONE edge for divide by zero). They are stable at all other times, including while busy. div_by_zero clears on the next accepted start.
- reset asserted in any state: at the next edge everything returns to its reset values and the in-flight result is discarded.
- reset and start asserted in the same cycle: reset wins and the start is lost.

Test Plan:
1. Unsigned: DIVU 100/7, start at T -> busy in T+1..T+33, done at T+34, quotient=14, remainder=2, div_by_zero=0.
2. Signed: DIV -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
3. Extremes: DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0. DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
4. Divide by zero: DIV 0x12345678/0 -> done at T+1, busy stays 0, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. A following 9/3 start clears div_by_zero and gives quotient=3, remainder=0.
5. Start while busy: start 100/7, pulse start with 50/5 at T+10 -> ignored; single done at T+34 with quotient=14, remainder=2.
6. Reset mid-operation: start 100/7, assert reset at T+15 for one cycle -> busy=0, done never pulses, outputs=0. A fresh 20/6 start then gives quotient=3, remainder=2 after WIDTH+2 cycles.
